decode_pipe_stage: RTL and testbench

DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

---
 rtl/decode_pipe_stage.sv | 114 +++++++++++
 tb/tb_decode_pipe_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe_stage.sv
// Decode pipeline stage: register file, immediate sign-extension, control decode, output register.
// Optional DECODE_WB_BYPASS_EN makes read ports write-first against the write-back port.
module decode_pipe_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned IMM_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [31:0]           instruction,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic                  r_write,
  input  logic [REG_ADDR_W-1:0] rd_write,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     pc_out,
  output logic [DATA_W-1:0]     dataA_out,
  output logic [DATA_W-1:0]     dataB_out,
  output logic [DATA_W-1:0]     sign_extend_out,
  output logic [REG_ADDR_W-1:0] rs_out,
  output logic [REG_ADDR_W-1:0] rt_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [1:0]            wb_out,
  output logic [2:0]            m_out,
  output logic [3:0]            ex_out
);

  localparam int unsigned NumRegs = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0]     rf_q [NumRegs];
  logic [5:0]            opcode;
  logic [REG_ADDR_W-1:0] rs_addr, rt_addr, rd_addr;
  logic [IMM_W-1:0]      imm;
  logic [DATA_W-1:0]     imm_ext;
  logic [DATA_W-1:0]     rdata_a, rdata_b;
  logic [1:0]            wb_d;
  logic [2:0]            m_d;
  logic [3:0]            ex_d;
  logic                  wr_en;

  assign opcode  = instruction[31:26];
  assign rs_addr = REG_ADDR_W'(instruction[25:21]);
  assign rt_addr = REG_ADDR_W'(instruction[20:16]);
  assign rd_addr = REG_ADDR_W'(instruction[15:11]);
  assign imm     = instruction[IMM_W-1:0];
  assign imm_ext = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
  assign wr_en   = r_write && (rd_write != '0);

  // Entry 0 is never written, and reads of it are forced to zero as well.
  always_comb begin
    rdata_a = (rs_addr == '0) ? '0 : rf_q[rs_addr];
    rdata_b = (rt_addr == '0) ? '0 : rf_q[rt_addr];
`ifdef DECODE_WB_BYPASS_EN
    if (wr_en && (rd_write == rs_addr)) rdata_a = data_in;
    if (wr_en && (rd_write == rt_addr)) rdata_b = data_in;
`endif
  end

  always_comb begin
    wb_d = '0;
    m_d  = '0;
    ex_d = '0;
    if (in_valid) begin
      case (opcode)
        6'b000000: begin wb_d = 2'b10; m_d = 3'b000; ex_d = 4'b1100; end
        6'b100011: begin wb_d = 2'b11; m_d = 3'b010; ex_d = 4'b0001; end
        6'b101011: begin wb_d = 2'b00; m_d = 3'b001; ex_d = 4'b0001; end
        6'b000100: begin wb_d = 2'b00; m_d = 3'b100; ex_d = 4'b0010; end
        default:   begin wb_d = '0;    m_d = '0;     ex_d = '0;      end
      endcase
    end
  end

  // Write-back keeps going through stall and flush; only reset blocks it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[rd_write] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid       <= 1'b0;
      pc_out          <= '0;
      dataA_out       <= '0;
      dataB_out       <= '0;
      sign_extend_out <= '0;
      rs_out          <= '0;
      rt_out          <= '0;
      rd_out          <= '0;
      wb_out          <= '0;
      m_out           <= '0;
      ex_out          <= '0;
    end else if (!stall) begin
      out_valid       <= in_valid;
      pc_out          <= pc_in;
      dataA_out       <= rdata_a;
      dataB_out       <= rdata_b;
      sign_extend_out <= imm_ext;
      rs_out          <= rs_addr;
      rt_out          <= rt_addr;
      rd_out          <= rd_addr;
      wb_out          <= wb_d;
      m_out           <= m_d;
      ex_out          <= ex_d;
    end
  end

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Randomized self-checking bench for decode_pipe_stage against a table-driven reference model.
module tb_decode_pipe_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, in_valid, r_write, stall, flush;
  logic [31:0]   instruction;
  logic [DW-1:0] pc_in, data_in;
  logic [AW-1:0] rd_write;
  logic          out_valid;
  logic [DW-1:0] pc_out, dataA_out, dataB_out, sign_extend_out;
  logic [AW-1:0] rs_out, rt_out, rd_out;
  logic [1:0]    wb_out;
  logic [2:0]    m_out;
  logic [3:0]    ex_out;

  decode_pipe_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .IMM_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction), .pc_in(pc_in),
    .r_write(r_write), .rd_write(rd_write), .data_in(data_in), .stall(stall), .flush(flush),
    .out_valid(out_valid), .pc_out(pc_out), .dataA_out(dataA_out), .dataB_out(dataB_out),
    .sign_extend_out(sign_extend_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
    .wb_out(wb_out), .m_out(m_out), .ex_out(ex_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference state: architectural register contents and expected output bundle.
  logic [31:0] m_rf [32];
  logic        e_valid;
  logic [31:0] e_pc, e_a, e_b, e_se;
  logic [4:0]  e_rs, e_rt, e_rd;
  logic [8:0]  e_ctrl;

  // {wb, m, ex} straight from the opcode table.
  function automatic logic [8:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b10_000_1100;
      6'h23:   return 9'b11_010_0001;
      6'h2B:   return 9'b00_001_0001;
      6'h04:   return 9'b00_100_0010;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [31:0] read_model(input logic [4:0] addr);
    if (addr == 0) return 32'h0;
`ifdef DECODE_WB_BYPASS_EN
    if (r_write && rd_write == addr) return data_in;
`endif
    return m_rf[addr];
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check_all();
    check_val("out_valid", 32'(out_valid), 32'(e_valid));
    check_val("pc_out", pc_out, e_pc);
    check_val("dataA_out", dataA_out, e_a);
    check_val("dataB_out", dataB_out, e_b);
    check_val("sign_extend_out", sign_extend_out, e_se);
    check_val("rs_out", 32'(rs_out), 32'(e_rs));
    check_val("rt_out", 32'(rt_out), 32'(e_rt));
    check_val("rd_out", 32'(rd_out), 32'(e_rd));
    check_val("ctrl", 32'({wb_out, m_out, ex_out}), 32'(e_ctrl));
  endtask

  // Advance one clock: predict from pre-edge state, then compare after the edge.
  task automatic step();
    if (rst || flush) begin
      {e_valid, e_pc, e_a, e_b, e_se, e_rs, e_rt, e_rd, e_ctrl} = '0;
    end else if (!stall) begin
      e_valid = in_valid;
      e_pc    = pc_in;
      e_a     = read_model(instruction[25:21]);
      e_b     = read_model(instruction[20:16]);
      e_se    = 32'(signed'(instruction[15:0]));
      e_rs    = instruction[25:21];
      e_rt    = instruction[20:16];
      e_rd    = instruction[15:11];
      e_ctrl  = in_valid ? ctrl_of(instruction[31:26]) : 9'b0;
    end
    if (rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    end else if (r_write && rd_write != 0) begin
      m_rf[rd_write] = data_in;
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_in();
    rst = 0; stall = 0; flush = 0; r_write = 0; rd_write = 0; data_in = 0;
    in_valid = 0; instruction = 0; pc_in = 0;
  endtask

  logic [5:0] ops [5] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h3F};

  initial begin
    idle_in();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'hX;
    @(negedge clk);

    rst = 1; step(); rst = 0;
    check_val("reset_valid", 32'(out_valid), 32'h0);

    // Reset clears the register file.
    r_write = 1; rd_write = 5; data_in = 32'hA5A5_0000; step(); idle_in();
    rst = 1; step(); rst = 0;
    in_valid = 1; instruction = mk(6'h00, 5, 0, 16'h0); step();
    check_val("r5_cleared", dataA_out, 32'h0);

    // lw after writing r3.
    idle_in(); r_write = 1; rd_write = 3; data_in = 32'h1234; step(); idle_in();
    in_valid = 1; instruction = 32'h8C64_FFFC; pc_in = 32'h40; step();
    check_val("lw_dataA", dataA_out, 32'h1234);
    check_val("lw_imm", sign_extend_out, 32'hFFFF_FFFC);
    check_val("lw_ctrl", 32'({wb_out, m_out, ex_out}), 32'(9'b11_010_0001));
    check_val("lw_rt", 32'(rt_out), 32'd4);
    check_val("lw_pc", pc_out, 32'h40);
    check_val("lw_valid", 32'(out_valid), 32'h1);

    // Writes to r0 are ignored.
    idle_in(); r_write = 1; rd_write = 0; data_in = 32'hDEAD; step(); idle_in();
    in_valid = 1; instruction = mk(6'h00, 0, 0, 16'h0); step();
    check_val("r0_zero", dataA_out, 32'h0);

    // Same-cycle write and read of r7.
    idle_in(); r_write = 1; rd_write = 7; data_in = 32'h77;
    in_valid = 1; instruction = mk(6'h00, 7, 0, 16'h0); step();
`ifdef DECODE_WB_BYPASS_EN
    check_val("same_cycle_r7", dataA_out, 32'h77);
`else
    check_val("same_cycle_r7", dataA_out, 32'h0);
`endif

    // Stall freezes outputs; flush during stall inserts a bubble.
    idle_in(); in_valid = 1; instruction = mk(6'h23, 7, 3, 16'h0010); pc_in = 32'h80; step();
    for (int i = 0; i < 3; i++) begin
      stall = 1; instruction = mk(6'h00, 5'(i), 5'(i + 1), 16'(i)); pc_in = 32'h100 + i;
      r_write = 1; rd_write = 5'(9 + i); data_in = 32'hC0DE_0000 + i;
      step();
      check_val("stall_pc", pc_out, 32'h80);
    end
    r_write = 0; flush = 1; stall = 1; step();
    check_val("flush_valid", 32'(out_valid), 32'h0);
    check_val("flush_ctrl", 32'({wb_out, m_out, ex_out}), 32'h0);

    // Unknown opcode decodes to no control.
    idle_in(); in_valid = 1; instruction = mk(6'h3F, 1, 2, 16'h1234); step();
    check_val("op3f_ctrl", 32'({wb_out, m_out, ex_out}), 32'h0);
    check_val("op3f_valid", 32'(out_valid), 32'h1);

    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 39) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      stall    = ($urandom_range(0, 4) == 0);
      r_write  = $urandom_range(0, 1);
      rd_write = 5'($urandom_range(0, 7));
      data_in  = $urandom;
      in_valid = ($urandom_range(0, 3) != 0);
      instruction = $urandom;
      instruction[31:26] = ops[$urandom_range(0, 4)];
      instruction[25:21] = 5'($urandom_range(0, 7));
      instruction[20:16] = 5'($urandom_range(0, 7));
      pc_in = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
